// File: rtl/controle_medicao_hcsr04.sv
// Measurement sequencer for the HC-SR04 sensor interface: periodic medir pulses, timeout
// supervision, BCD validation of each reading and a debounced "object near" flag.
module controle_medicao_hcsr04 #(
    parameter int          PERIODO  = 12_500_000,
    parameter int          TIMEOUT  = 2_500_000,
    parameter logic [11:0] LIMITE   = 12'h020,
    parameter int          CONFIRMA = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ligar,
    input  logic        pronto_sensor,
    input  logic [11:0] medida_sensor,
    output logic        medir,
    output logic [11:0] distancia,
    output logic        nova_medida,
    output logic        proximo,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int PW = (PERIODO > 2) ? $clog2(PERIODO) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [PW-1:0] PER_FIM  = PW'(PERIODO - 1);
    localparam logic [TW-1:0] TMO_FIM  = TW'(TIMEOUT - 1);
    localparam logic [3:0]    CONF_MAX = 4'(CONFIRMA);

    localparam logic [2:0] INICIAL  = 3'd0;
    localparam logic [2:0] ESPERA   = 3'd1;
    localparam logic [2:0] PEDE     = 3'd2;
    localparam logic [2:0] AGUARDA  = 3'd3;
    localparam logic [2:0] REGISTRA = 3'd4;
    localparam logic [2:0] FALHA    = 3'd6;

    logic [2:0]    estado_q, estado_d;
    logic [PW-1:0] per_q, per_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    conf_q, conf_d;
    logic [11:0]   captura_q, captura_d;
    logic [11:0]   dist_q, dist_d;
    logic          erro_q, erro_d;
    logic          nova_q, nova_d;
    logic          prox_q, prox_d;

    logic [2:0]    digito_ok;
    logic          bcd_ok;
    logic          perto;
    logic [3:0]    conf_inc;
    logic [PW-1:0] per_inc;
    logic [TW-1:0] tmo_inc;

    // A reading is only trusted if each packed digit is a legal decimal digit.
    for (genvar gi = 0; gi < 3; gi++) begin : g_digito
        assign digito_ok[gi] = (captura_q[4*gi +: 4] <= 4'd9);
    end

    assign bcd_ok   = &digito_ok;
    assign perto    = (captura_q < LIMITE);
    assign conf_inc = (conf_q >= CONF_MAX) ? CONF_MAX : conf_q + 4'd1;
    assign per_inc  = (per_q == {PW{1'b1}}) ? per_q : per_q + PW'(1);
    assign tmo_inc  = (tmo_q == {TW{1'b1}}) ? tmo_q : tmo_q + TW'(1);

    always_comb begin
        estado_d  = estado_q;
        conf_d    = conf_q;
        captura_d = captura_q;
        dist_d    = dist_q;
        erro_d    = erro_q;
        nova_d    = 1'b0;

        case (estado_q)
            INICIAL: begin
                if (ligar) estado_d = PEDE;
            end
            PEDE: begin
                estado_d = AGUARDA;
            end
            AGUARDA: begin
                // A pronto arriving on the expiry cycle still counts as on time.
                if (pronto_sensor) begin
                    captura_d = medida_sensor;
                    estado_d  = REGISTRA;
                end else if (tmo_q >= TMO_FIM) begin
                    estado_d = FALHA;
                end
            end
            REGISTRA: begin
                if (bcd_ok) begin
                    dist_d = captura_q;
                    nova_d = 1'b1;
                    erro_d = 1'b0;
                    conf_d = perto ? conf_inc : 4'd0;
                end else begin
                    erro_d = 1'b1;
                    conf_d = 4'd0;
                end
                estado_d = ESPERA;
            end
            FALHA: begin
                erro_d   = 1'b1;
                conf_d   = 4'd0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (per_q >= PER_FIM) estado_d = PEDE;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase

        // Dropping ligar abandons whatever is in flight but keeps the last result visible.
        if (!ligar) begin
            estado_d  = INICIAL;
            conf_d    = 4'd0;
            captura_d = captura_q;
            dist_d    = dist_q;
            erro_d    = erro_q;
            nova_d    = 1'b0;
        end

        // Period counter reads 0 during the PEDE cycle itself, so pulses land PERIODO apart.
        per_d  = (estado_d == PEDE) ? '0 : per_inc;
        tmo_d  = (estado_q == AGUARDA) ? tmo_inc : '0;
        prox_d = (conf_d == CONF_MAX);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= INICIAL;
            per_q     <= '0;
            tmo_q     <= '0;
            conf_q    <= 4'd0;
            captura_q <= 12'h000;
            dist_q    <= 12'h000;
            erro_q    <= 1'b0;
            nova_q    <= 1'b0;
            prox_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            per_q     <= per_d;
            tmo_q     <= tmo_d;
            conf_q    <= conf_d;
            captura_q <= captura_d;
            dist_q    <= dist_d;
            erro_q    <= erro_d;
            nova_q    <= nova_d;
            prox_q    <= prox_d;
        end
    end

    assign medir       = (estado_q == PEDE);
    assign distancia   = dist_q;
    assign nova_medida = nova_q;
    assign proximo     = prox_q;
    assign erro        = erro_q;
    assign db_estado   = {1'b0, estado_q};

endmodule
